// File: rtl/gpio_in_conditioner_if.sv
// Pad-side and GPIO-side signal bundle of the GPIO input conditioner.
// The conditioner sits on the slave side and the bench or parent drives the master side.
interface gpio_in_conditioner_if;
  logic [15:0] PADIN;
  logic        ENABLE;
  logic        PARITYSEL;
  logic        PERR_INJ;
  logic        EVTCLR;
  logic [16:0] GPIOIN;
  logic        CHG_PULSE;
  logic [7:0]  EVTCNT;

  modport master (
    output PADIN, ENABLE, PARITYSEL, PERR_INJ, EVTCLR,
    input  GPIOIN, CHG_PULSE, EVTCNT
  );

  modport slave (
    input  PADIN, ENABLE, PARITYSEL, PERR_INJ, EVTCLR,
    output GPIOIN, CHG_PULSE, EVTCNT
  );
endinterface

// File: rtl/gpio_in_conditioner.sv
// GPIO input front end: it synchronises and debounces 16 pads, then appends a selectable parity bit.
// It also produces a change pulse, a saturating change counter and a one-cycle parity-error injection.
module gpio_in_conditioner #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 4
) (
  input logic             HCLK,
  input logic             HRESETn,
  gpio_in_conditioner_if.slave gpio
);

  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DB_CYCLES < 1 || DB_CYCLES > 255) begin : g_param_check
    $error("gpio_in_conditioner: SYNC_STAGES or DB_CYCLES out of range");
  end

  logic [SYNC_STAGES-1:0][15:0] sync_q;
  logic [15:0]                  sync_s;
  logic [15:0][CNT_W-1:0]       cnt_q;
  logic [15:0][CNT_W-1:0]       cnt_d;
  logic [15:0]                  stable_q;
  logic [15:0]                  stable_d;
  logic                         update;
  logic                         inj_q;
  logic                         chg_q;
  logic [7:0]                   evt_q;
  logic [7:0]                   evt_d;
  logic                         parity;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpio.PADIN};
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // A bit is accepted on the edge where its counter is already at DB_CYCLES-1.
  // That takes DB_CYCLES consecutive differing samples, with no extra cycle to commit.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (gpio.ENABLE && (sync_s[i] != stable_q[i])) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync_s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign update = (stable_d != stable_q);

  always_comb begin
    evt_d = evt_q;
    if (gpio.EVTCLR) begin
      evt_d = {7'd0, update};
    end else if (update && (evt_q != 8'hFF)) begin
      evt_d = evt_q + 8'd1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q    <= '0;
      stable_q <= '0;
      chg_q    <= 1'b0;
      evt_q    <= '0;
      inj_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      chg_q    <= update;
      evt_q    <= evt_d;
      inj_q    <= ~inj_q & gpio.PERR_INJ;
    end
  end

  assign parity         = (gpio.PARITYSEL ? ~^stable_q : ^stable_q) ^ inj_q;
  assign gpio.GPIOIN    = {parity, stable_q};
  assign gpio.CHG_PULSE = chg_q;
  assign gpio.EVTCNT    = evt_q;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Scoreboard bench for gpio_in_conditioner: a driver pushes model predictions for each edge.
// A monitor pops each prediction and compares it with the DUT after the edge.
module tb_gpio_in_conditioner;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DB   = 4;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;

  gpio_in_conditioner_if bus ();

  gpio_in_conditioner #(
    .SYNC_STAGES(SYNC),
    .DB_CYCLES  (DB)
  ) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .gpio   (bus.slave)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [16:0] g;
    logic        c;
    logic [7:0]  e;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // stimulus registers
  logic [15:0] pad  = '0;
  logic        en   = 1'b1;
  logic        psel = 1'b1;
  logic        perr = 1'b0;
  logic        clr  = 1'b0;
  logic        rstn = 1'b0;
  logic        rstn_prev = 1'b0;

  // reference model: sample history, accepted word, run lengths of differing samples
  logic [15:0] m_hist[$];
  logic [15:0] m_acc;
  int          m_run[16];
  bit          m_inj;
  bit          m_chg;
  int          m_evt;

  function automatic void model_reset();
    m_hist.delete();
    for (int i = 0; i < SYNC; i++) m_hist.push_back(16'h0000);
    m_acc = '0;
    for (int i = 0; i < 16; i++) m_run[i] = 0;
    m_inj = 0;
    m_chg = 0;
    m_evt = 0;
  endfunction

  function automatic void model_edge(input logic [15:0] p, input bit e, input bit pe, input bit c);
    logic [15:0] s;
    logic [15:0] old;
    bit          changed;
    s   = m_hist.pop_front();
    m_hist.push_back(p);
    old = m_acc;
    for (int i = 0; i < 16; i++) begin
      if (!e || s[i] == m_acc[i]) m_run[i] = 0;
      else begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_acc[i] = s[i];
          m_run[i] = 0;
        end
      end
    end
    changed = (m_acc != old);
    if (c) m_evt = changed ? 1 : 0;
    else if (changed && m_evt < 255) m_evt++;
    m_chg = changed;
    m_inj = !m_inj && pe;
  endfunction

  function automatic exp_t model_out(input bit ps);
    exp_t x;
    bit   par;
    par   = (($countones(m_acc) % 2) == 1) ^ ps ^ m_inj;
    x.g   = {par, m_acc};
    x.c   = m_chg;
    x.e   = m_evt[7:0];
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs just after a falling edge, predict the next rising edge, wait a cycle.
  task automatic step();
    bus.PADIN     = pad;
    bus.ENABLE    = en;
    bus.PARITYSEL = psel;
    bus.PERR_INJ  = perr;
    bus.EVTCLR    = clr;
    HRESETn       = rstn;
    if (!rstn) model_reset();
    else model_edge(pad, en, perr, clr);
    if (!rstn && rstn_prev) begin
      #1;
      check("async_rst_gpioin", bus.GPIOIN, {psel, 16'h0000});
      check("async_rst_chg", bus.CHG_PULSE, 0);
      check("async_rst_evt", bus.EVTCNT, 0);
    end
    rstn_prev = rstn;
    sb.push_back(model_out(psel));
    @(negedge HCLK);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge HCLK);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check("gpioin", bus.GPIOIN, x.g);
        check("chg_pulse", bus.CHG_PULSE, x.c);
        check("evtcnt", bus.EVTCNT, x.e);
      end
    end
  end

  initial begin : driver
    model_reset();
    repeat (3) step();
    psel = 1'b0;
    repeat (2) step();
    rstn = 1'b1;
    repeat (3) step();

    pad = 16'h0005;
    repeat (8) step();
    check("clean_step_data", bus.GPIOIN, 17'h00005);
    check("clean_step_evt", bus.EVTCNT, 1);

    pad = 16'h000D;
    repeat (3) step();
    pad = 16'h0005;
    repeat (8) step();
    check("glitch_data", bus.GPIOIN, 17'h00005);
    check("glitch_evt", bus.EVTCNT, 1);

    pad  = 16'h0001;
    psel = 1'b1;
    repeat (8) step();
    check("odd_parity", bus.GPIOIN[16], 0);
    bus.PARITYSEL = 1'b0;
    #1;
    check("even_parity_same_cycle", bus.GPIOIN[16], 1);
    psel = 1'b0;
    step();
    perr = 1'b1;
    step();
    perr = 1'b0;
    repeat (3) step();
    perr = 1'b1;
    repeat (6) step();
    perr = 1'b0;
    repeat (2) step();

    en  = 1'b0;
    pad = 16'hFFFF;
    repeat (20) step();
    check("freeze_data", bus.GPIOIN[15:0], 16'h0001);
    en = 1'b1;
    repeat (6) step();
    check("unfreeze_data", bus.GPIOIN[15:0], 16'hFFFF);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(3) == 0) pad = 16'($urandom);
      en   = ($urandom_range(7) != 0);
      psel = 1'($urandom_range(1));
      perr = ($urandom_range(3) == 0);
      clr  = ($urandom_range(15) == 0);
      step();
    end

    en   = 1'b1;
    perr = 1'b0;
    clr  = 1'b1;
    step();
    clr = 1'b0;
    repeat (8) step();
    for (int n = 0; n < 300; n++) begin
      pad[0] = ~pad[0];
      repeat (6) step();
    end
    check("evt_saturate", bus.EVTCNT, 255);

    pad[0] = ~pad[0];
    repeat (5) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("evtclr_with_pulse", bus.EVTCNT, 1);
    check("evtclr_pulse_seen", bus.CHG_PULSE, 1);

    pad[0] = ~pad[0];
    repeat (3) step();
    rstn = 1'b0;
    repeat (2) step();
    rstn = 1'b1;
    repeat (10) step();

    repeat (2) @(negedge HCLK);
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
